// File: rtl/fp_mant_mul_seq.sv
// Iterative shift-and-add significand multiplier: one WIDTH-bit partial-product add per clock.
// Optional zero-operand fast path enabled by defining FP_MUL_ZERO_SKIP_EN.
module fp_mant_mul_seq #(
   parameter int WIDTH = 24
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a_mant,
   input  logic [WIDTH-1:0]   b_mant,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int               CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state;
   logic [WIDTH-1:0]   mcand;
   // {upper, lower}; the carry bit is always shifted straight back into upper, so it is not stored
   logic [2*WIDTH-1:0] acc;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] acc_next;
   logic               zero_op;

`ifdef FP_MUL_ZERO_SKIP_EN
   assign zero_op = (a_mant == '0) || (b_mant == '0);
`else
   assign zero_op = 1'b0;
`endif

   always_comb begin
      sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
      acc_next = {sum, acc[WIDTH-1:1]};
   end

   // NOTE: all state uses non-blocking assignments so every register updates from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         mcand   <= '0;
         acc     <= '0;
         cnt     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (zero_op) begin
                     product <= '0;
                     done    <= 1'b1;
                  end else begin
                     mcand <= a_mant;
                     acc   <= {{WIDTH{1'b0}}, b_mant};
                     cnt   <= '0;
                     busy  <= 1'b1;
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               acc <= acc_next;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  product <= acc_next;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_mant_mul_seq.sv
// Directed self-checking bench for fp_mant_mul_seq; inputs driven and outputs sampled on the falling edge.
// Zero-operand expectations follow FP_MUL_ZERO_SKIP_EN when it is defined.
module tb_fp_mant_mul_seq;

   localparam int WIDTH = 24;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic [WIDTH-1:0]   a_mant;
   logic [WIDTH-1:0]   b_mant;
   logic               busy;
   logic               done;
   logic [2*WIDTH-1:0] product;

   int n_checks = 0;
   int n_errors = 0;
   int n_done   = 0;

   fp_mant_mul_seq #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a_mant  (a_mant),
      .b_mant  (b_mant),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (!rst && done) n_done++;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called on a falling edge after the accepting edge; lat counts edges since the accepting edge.
   task automatic wait_done(input int k0, output int lat, output int bc);
      lat = k0;
      bc  = 0;
      while (lat < 200 && !done) begin
         if (busy) bc++;
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      if (lat >= 200) check("timeout", 64'(lat), 64'(WIDTH));
   endtask

   task automatic accept(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      @(negedge clk);
      a_mant = a;
      b_mant = b;
      start  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [2*WIDTH-1:0] exp, input int exp_lat);
      int lat, bc;
      accept(a, b);
      wait_done(0, lat, bc);
      check({tag, "_lat"},  64'(lat), 64'(exp_lat));
      check({tag, "_busy_cycles"}, 64'(bc), 64'(exp_lat));
      check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
      check({tag, "_product"}, 64'(product), 64'(exp));
      @(negedge clk);
      check({tag, "_done_pulse"}, 64'(done), 64'd0);
      check({tag, "_product_held"}, 64'(product), 64'(exp));
   endtask

   initial begin
      int lat, bc, d0;
      rst    = 1'b1;
      start  = 1'b0;
      a_mant = '0;
      b_mant = '0;
      #23;
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_product", 64'(product), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // 1 and 2: basic products and boundary full-scale operand
      run_op("t1", 24'h800000, 24'h800000, 48'h400000000000, WIDTH);
      run_op("t2", 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, WIDTH);

      // 3: start pulse at E5 while busy must be ignored
      d0 = n_done;
      accept(24'hC00000, 24'hA00000);
      repeat (4) begin @(posedge clk); @(negedge clk); end
      a_mant = 24'hFFFFFF;
      b_mant = 24'hFFFFFF;
      start  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      wait_done(5, lat, bc);
      check("t3_lat", 64'(lat), 64'(WIDTH));
      check("t3_product", 64'(product), 64'h780000000000);
      repeat (30) @(negedge clk);
      check("t3_one_done", 64'(n_done - d0), 64'd1);
      check("t3_product_held", 64'(product), 64'h780000000000);
      check("t3_idle", 64'(busy), 64'd0);

      // 4: asynchronous reset mid-operation, then a fresh operation
      accept(24'hFFFFFF, 24'hFFFFFF);
      repeat (10) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("t4_rst_busy", 64'(busy), 64'd0);
      check("t4_rst_done", 64'(done), 64'd0);
      check("t4_rst_product", 64'(product), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      run_op("t4", 24'h800001, 24'h800000, 48'h400000800000, WIDTH);

      // 5: start held high gives back-to-back operations
      @(negedge clk);
      a_mant = 24'h900000;
      b_mant = 24'h800000;
      start  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      wait_done(0, lat, bc);
      check("t5a_lat", 64'(lat), 64'(WIDTH));
      check("t5a_product", 64'(product), 64'h480000000000);
      a_mant = 24'hC00000;
      @(posedge clk);
      @(negedge clk);
      check("t5_no_bubble_busy", 64'(busy), 64'd1);
      check("t5_prev_product_held", 64'(product), 64'h480000000000);
      wait_done(0, lat, bc);
      start = 1'b0;
      check("t5b_lat", 64'(lat), 64'(WIDTH));
      check("t5b_product", 64'(product), 64'h600000000000);
      @(negedge clk);
      check("t5_idle_after", 64'(busy), 64'd0);

      // 6: zero operand
`ifdef FP_MUL_ZERO_SKIP_EN
      run_op("t6", 24'h000000, 24'hABCDEF, 48'h0, 0);
`else
      run_op("t6", 24'h000000, 24'hABCDEF, 48'h0, WIDTH);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
      $fatal(1);
   end

endmodule
